// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_shifter
//  Description : SPI mode-0 master serial engine. Accepts one parallel word
//                per frame via valid/ready, shifts it out MSB-first on mosi
//                while capturing miso, then presents the received word with
//                a one-cycle rx_valid pulse as chip select is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int CLK_DIV        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    output logic                      cs_n
);

    localparam int C_N     = SPI_DATA_WIDTH;
    localparam int C_CNT_W = $clog2(C_N + 1);
    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_DIV_W-1:0] C_DIV_ONE  = C_DIV_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_N - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_TRAIL = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [C_DIV_W-1:0] r_div;
    logic [C_CNT_W-1:0] r_bit_cnt;
    logic [C_N-1:0]     r_tx_sh;
    logic [C_N-1:0]     r_rx_sh;
    logic [C_N-1:0]     r_rx_data;
    logic               r_rx_valid;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_cs_n;

    logic               w_handshake;
    logic               w_div_wrap;
    logic               w_rise;
    logic               w_fall;
    logic               w_last_fall;
    logic               w_trail_done;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> SHIFT on handshake, SHIFT -> TRAIL after the
    // last sclk fall, TRAIL -> IDLE after one extra half-period
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_handshake)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_fall)  w_state_nxt = S_TRAIL;
            S_TRAIL: if (w_trail_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Event strobes derived from state, divider and current sclk level
    always_comb begin
        w_handshake  = (r_state == S_IDLE) && tx_valid && r_tx_ready;
        w_div_wrap   = (r_div == C_DIV_LAST);
        w_rise       = (r_state == S_SHIFT) && w_div_wrap && !r_sclk;
        w_fall       = (r_state == S_SHIFT) && w_div_wrap && r_sclk;
        w_last_fall  = w_fall && (r_bit_cnt == C_CNT_LAST);
        w_trail_done = (r_state == S_TRAIL) && w_div_wrap;
    end

    // Registered datapath and outputs; rx_valid defaults low so it only pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_tx_sh    <= tx_data;
                        r_mosi     <= tx_data[C_N-1];
                        r_cs_n     <= 1'b0;
                        r_sclk     <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_div      <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_div <= w_div_wrap ? '0 : (r_div + C_DIV_ONE);
                    if (w_div_wrap) begin
                        r_sclk <= ~r_sclk;
                    end
                    if (w_rise) begin
                        r_rx_sh <= {r_rx_sh[C_N-2:0], miso};
                    end
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + C_CNT_ONE;
                        // The final bit stays on mosi through the trailing half-period
                        if (!w_last_fall) begin
                            r_tx_sh <= r_tx_sh << 1;
                            r_mosi  <= r_tx_sh[C_N-2];
                        end
                    end
                end
                S_TRAIL: begin
                    r_div <= w_div_wrap ? '0 : (r_div + C_DIV_ONE);
                    if (w_trail_done) begin
                        r_cs_n     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_mosi     <= 1'b0;
                    end
                end
                default: begin
                    r_div <= '0;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_shifter
//  Description : Self-checking bench for spi_master_shifter (D=2 and D=1
//                instances) with an SPI slave model and frame monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_shifter;

    localparam int N  = 8;
    localparam int DA = 2;
    localparam int DB = 1;

    logic clk;
    logic rst_n;

    // instance A (D=2)
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         cs_n;

    // instance B (D=1, loopback)
    logic [N-1:0] tx_data_b;
    logic         tx_valid_b;
    logic         tx_ready_b;
    logic [N-1:0] rx_data_b;
    logic         rx_valid_b;
    logic         busy_b;
    logic         sclk_b;
    logic         mosi_b;
    logic         cs_n_b;

    int errors = 0;
    int checks = 0;

    spi_master_shifter #(.SPI_DATA_WIDTH(N), .CLK_DIV(DA)) u_dut (
        .clk(clk), .reset(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    spi_master_shifter #(.SPI_DATA_WIDTH(N), .CLK_DIV(DB)) u_dut_b (
        .clk(clk), .reset(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b), .cs_n(cs_n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model / miso source for instance A -------------
    bit           loop_a = 1'b1;
    logic [N-1:0] miso_word = '0;
    logic [N-1:0] slave_sh  = '0;
    assign miso = loop_a ? mosi : slave_sh[N-1];

    // ---------------- frame monitor for instance A --------------------------
    int  low_a = 0, hi_a = 0, rises_a = 0, first_a = -1, lastrise_a = 0, badper_a = 0;
    int  fr_low_a = 0, fr_rises_a = 0, fr_first_a = 0, fr_badper_a = 0, last_hi_a = 0;
    int  trlow_a = 0, last_trlow_a = 0, frames_a = 0, rxv_a = 0, badrxv_a = 0, busybad_a = 0;
    logic [N-1:0] mosi_w_a = '0, fr_mosi_a = '0;
    logic [N-1:0] rxq[$];
    logic pcs = 1'b1, psclk = 1'b0, ptr = 1'b1;

    // Per-sample bookkeeping of cs_n/sclk/tx_ready activity on instance A
    always @(negedge clk) begin
        if (!rst_n) begin
            pcs = 1'b1; psclk = 1'b0; ptr = 1'b1; hi_a = 0; low_a = 0;
        end else begin
            if (busy !== !cs_n) busybad_a++;
            if (rx_valid) begin
                rxv_a++;
                rxq.push_back(rx_data);
                if (!(pcs == 1'b0 && cs_n == 1'b1)) badrxv_a++;
            end
            if (cs_n == 1'b0) begin
                if (pcs == 1'b1) begin
                    last_hi_a = hi_a; low_a = 0; rises_a = 0; first_a = -1;
                    badper_a = 0; mosi_w_a = '0; slave_sh = miso_word;
                end
                low_a++;
                if (psclk == 1'b0 && sclk == 1'b1) begin
                    rises_a++;
                    mosi_w_a = {mosi_w_a[N-2:0], mosi};
                    if (rises_a == 1) first_a = low_a - 1;
                    else if (low_a - lastrise_a != 2 * DA) badper_a++;
                    lastrise_a = low_a;
                end
                if (psclk == 1'b1 && sclk == 1'b0) slave_sh = slave_sh << 1;
            end else begin
                if (pcs == 1'b0) begin
                    frames_a++; fr_low_a = low_a; fr_rises_a = rises_a;
                    fr_first_a = first_a; fr_badper_a = badper_a; fr_mosi_a = mosi_w_a;
                    hi_a = 0;
                end
                hi_a++;
            end
            if (tx_ready == 1'b0) begin
                if (ptr == 1'b1) trlow_a = 0;
                trlow_a++;
            end else if (ptr == 1'b0) begin
                last_trlow_a = trlow_a;
            end
            pcs = cs_n; psclk = sclk; ptr = tx_ready;
        end
    end

    // ---------------- frame monitor for instance B --------------------------
    int  low_b = 0, rises_b = 0, first_b = -1, lastrise_b = 0, badper_b = 0;
    int  fr_low_b = 0, fr_rises_b = 0, fr_first_b = 0, fr_badper_b = 0, frames_b = 0, rxv_b = 0;
    logic fr_rxv_b = 1'b0;
    logic pcs_b = 1'b1, psclk_b = 1'b0;

    // Same frame measurements for the D=1 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            pcs_b = 1'b1; psclk_b = 1'b0;
        end else begin
            if (rx_valid_b) rxv_b++;
            if (cs_n_b == 1'b0) begin
                if (pcs_b == 1'b1) begin
                    low_b = 0; rises_b = 0; first_b = -1; badper_b = 0;
                end
                low_b++;
                if (psclk_b == 1'b0 && sclk_b == 1'b1) begin
                    rises_b++;
                    if (rises_b == 1) first_b = low_b - 1;
                    else if (low_b - lastrise_b != 2 * DB) badper_b++;
                    lastrise_b = low_b;
                end
            end else if (pcs_b == 1'b0) begin
                frames_b++; fr_low_b = low_b; fr_rises_b = rises_b;
                fr_first_b = first_b; fr_badper_b = badper_b; fr_rxv_b = rx_valid_b;
            end
            pcs_b = cs_n_b; psclk_b = sclk_b;
        end
    end

    // ---------------- reference model and helpers ---------------------------
    // Received word: loopback returns what was sent; otherwise the slave's word
    function automatic logic [N-1:0] ref_rx(input bit lp, input logic [N-1:0] tx,
                                            input logic [N-1:0] m);
        return lp ? tx : m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [N-1:0] w, input bit lp, input logic [N-1:0] mw);
        int n;
        loop_a = lp;
        miso_word = mw;
        n = 0;
        while (!tx_ready && n < 200) begin step(); n++; end
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = ~w;
    endtask

    task automatic wait_a(input string nm, input int tgt, input logic [N-1:0] exp_rx,
                          input logic [N-1:0] exp_mosi);
        int n;
        logic [N-1:0] lastq;
        n = 0;
        while (frames_a < tgt && n < 400) begin step(); n++; end
        chk({nm, " done"}, frames_a, tgt);
        if (frames_a < tgt) return;
        lastq = (rxq.size() > 0) ? rxq[rxq.size()-1] : ~exp_rx;
        chk({nm, " cs_low"}, fr_low_a, DA * (2 * N + 1));
        chk({nm, " rises"}, fr_rises_a, N);
        chk({nm, " first_rise"}, fr_first_a, DA);
        chk({nm, " sclk_period"}, fr_badper_a, 0);
        chk({nm, " mosi_bits"}, {24'h0, fr_mosi_a}, {24'h0, exp_mosi});
        chk({nm, " rx_data"}, {24'h0, rx_data}, {24'h0, exp_rx});
        chk({nm, " rx_pulse_word"}, {24'h0, lastq}, {24'h0, exp_rx});
        chk({nm, " rx_pulse_count"}, rxv_a, frames_a);
        chk({nm, " rx_pulse_at_cs_rise"}, badrxv_a, 0);
        chk({nm, " tx_ready_low"}, last_trlow_a, DA * (2 * N + 1));
        chk({nm, " busy"}, busybad_a, 0);
    endtask

    task automatic run_b(input string nm, input logic [N-1:0] w);
        int n, tgt;
        tgt = frames_b + 1;
        n = 0;
        while (!tx_ready_b && n < 200) begin step(); n++; end
        tx_data_b  = w;
        tx_valid_b = 1'b1;
        step();
        tx_valid_b = 1'b0;
        tx_data_b  = ~w;
        n = 0;
        while (frames_b < tgt && n < 200) begin step(); n++; end
        chk({nm, " done"}, frames_b, tgt);
        chk({nm, " cs_low"}, fr_low_b, DB * (2 * N + 1));
        chk({nm, " rises"}, fr_rises_b, N);
        chk({nm, " first_rise"}, fr_first_b, DB);
        chk({nm, " sclk_period"}, fr_badper_b, 0);
        chk({nm, " rx_data"}, {24'h0, rx_data_b}, {24'h0, w});
        chk({nm, " rx_valid"}, {31'h0, fr_rxv_b}, 32'h1);
        chk({nm, " rx_pulse_count"}, rxv_b, frames_b);
    endtask

    typedef struct {
        logic [N-1:0] tx;
        bit           lp;
        logic [N-1:0] mw;
        logic [N-1:0] exp_rx;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int fs, n, rxv_before;
        logic [N-1:0] w, m;
        bit lp;

        tbl[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5};
        tbl[1] = '{8'h00, 1'b0, 8'hFF, 8'hFF};
        tbl[2] = '{8'h81, 1'b1, 8'h00, 8'h81};
        tbl[3] = '{8'h7E, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{8'h3C, 1'b0, 8'hC5, 8'hC5};

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
        tx_valid_b = 1'b0; tx_data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset cs_n", {31'h0, cs_n}, 32'h1);
        chk("reset sclk", {31'h0, sclk}, 32'h0);
        chk("reset mosi", {31'h0, mosi}, 32'h0);
        chk("reset tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("reset rx_data", {24'h0, rx_data}, 32'h0);

        // table-driven frames
        for (int i = 0; i < 5; i++) begin
            fs = frames_a;
            start_a(tbl[i].tx, tbl[i].lp, tbl[i].mw);
            wait_a($sformatf("vec%0d", i), fs + 1, tbl[i].exp_rx, tbl[i].tx);
        end
        step();
        chk("idle mosi after 0x3C", {31'h0, mosi}, 32'h0);

        // randomized frames against the reference model
        for (int i = 0; i < 6; i++) begin
            w  = N'($urandom);
            m  = N'($urandom);
            lp = bit'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
            fs = frames_a;
            start_a(w, lp, m);
            wait_a($sformatf("rand%0d", i), fs + 1, ref_rx(lp, w, m), w);
        end

        // back-to-back frames with tx_valid held high
        loop_a = 1'b1;
        fs = frames_a;
        tx_data = 8'hAA; tx_valid = 1'b1;
        step();
        tx_data = 8'h55;
        n = 0;
        while (frames_a < fs + 1 && n < 400) begin step(); n++; end
        tx_valid = 1'b0;
        chk("b2b first rx", {24'h0, rx_data}, 32'hAA);
        wait_a("b2b second", fs + 2, 8'h55, 8'h55);
        chk("b2b cs_n gap", last_hi_a, 1);
        repeat (80) step();
        chk("b2b no third frame", frames_a, fs + 2);

        // tx_valid pulse while busy is ignored
        fs = frames_a;
        start_a(8'h81, 1'b1, 8'h00);
        repeat (9) step();
        tx_data = 8'h3C; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        wait_a("ignored pulse", fs + 1, 8'h81, 8'h81);
        repeat (80) step();
        chk("ignored pulse no extra frame", frames_a, fs + 1);

        // reset mid-frame
        fs = frames_a;
        rxv_before = rxv_a;
        start_a(8'hF0, 1'b1, 8'h00);
        repeat (11) step();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("midreset cs_n", {31'h0, cs_n}, 32'h1);
        chk("midreset sclk", {31'h0, sclk}, 32'h0);
        chk("midreset busy", {31'h0, busy}, 32'h0);
        chk("midreset tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("midreset rx_data", {24'h0, rx_data}, 32'h0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("midreset no rx_valid", rxv_a, rxv_before);
        chk("midreset no frame", frames_a, fs);
        start_a(8'h0F, 1'b1, 8'h00);
        wait_a("after reset", fs + 1, 8'h0F, 8'h0F);

        // D=1 instance
        run_b("d1 0xC3", 8'hC3);
        run_b("d1 rand", N'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
